// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle sequencer: state and class encodings,
// datapath mux/ALU constants and the opcode range boundaries.
package ctrl_defs;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_IMM = 3'd1,
        CL_BR  = 3'd2,
        CL_J   = 3'd3,
        CL_LD  = 3'd4,
        CL_ST  = 3'd5,
        CL_ILL = 3'd6
    } class_e;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_IMM   = 2'd3;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_SEXT  = 2'd2;
    localparam logic [1:0] SRCB_SHIFT = 2'd3;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Opcode range boundaries
    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_BR_ONE = 6'd1;
    localparam logic [5:0] OP_JUMP   = 6'd2;
    localparam logic [5:0] OP_BR_LO  = 6'd4;
    localparam logic [5:0] OP_BR_HI  = 6'd7;
    localparam logic [5:0] OP_IMM_LO = 6'd8;
    localparam logic [5:0] OP_IMM_HI = 6'd14;
    localparam logic [5:0] OP_LD_LO  = 6'd32;
    localparam logic [5:0] OP_LD_HI  = 6'd38;
    localparam logic [5:0] OP_ST_LO  = 6'd40;
    localparam logic [5:0] OP_ST_HI  = 6'd46;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
// Memory handshake: mem_req is the valid, mem_ready the ready. An access
// completes on a cycle where both are high. Once mem_req rises it stays high,
// with iord and mem_read/mem_write unchanged, until that completing cycle.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       bus_error;
    logic       retired;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_read, mem_write, iord, ir_write, pc_write,
               pc_write_cond, alu_src_a, alu_src_b, alu_op, pc_source,
               reg_write, reg_dst, mem_to_reg, illegal, bus_error, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_read, mem_write, iord, ir_write, pc_write,
               pc_write_cond, alu_src_a, alu_src_b, alu_op, pc_source,
               reg_write, reg_dst, mem_to_reg, illegal, bus_error, retired
    );
endinterface

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational opcode -> instruction class decoder.
module opcode_class
    import ctrl_defs::*;
(
    input  logic [5:0] opcode_i,
    output class_e     class_o
);

    // Range compare against the opcode map; anything unmatched is illegal
    always_comb begin
        class_o = CL_ILL;
        if (opcode_i == OP_RTYPE) begin
            class_o = CL_R;
        end else if (opcode_i == OP_JUMP) begin
            class_o = CL_J;
        end else if (opcode_i == OP_BR_ONE ||
                     (opcode_i >= OP_BR_LO && opcode_i <= OP_BR_HI)) begin
            class_o = CL_BR;
        end else if (opcode_i >= OP_IMM_LO && opcode_i <= OP_IMM_HI) begin
            class_o = CL_IMM;
        end else if (opcode_i >= OP_LD_LO && opcode_i <= OP_LD_HI) begin
            class_o = CL_LD;
        end else if (opcode_i >= OP_ST_LO && opcode_i <= OP_ST_HI) begin
            class_o = CL_ST;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: steps the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB and waits on the memory handshake with a timeout.
module multicycle_ctrl
    import ctrl_defs::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus,
    output state_e             dbg_state_o
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    class_e     cls_q, cls_d;
    class_e     dec_cls;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       bus_error_q, bus_error_d;
    logic       in_access;

    opcode_class u_opcode_class (
        .opcode_i (bus.opcode),
        .class_o  (dec_cls)
    );

    assign in_access   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign dbg_state_o = state_q;
    assign bus.illegal   = illegal_q;
    assign bus.bus_error = bus_error_q;

    // State, latched class, wait counter and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            cls_q       <= CL_R;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            wait_q      <= wait_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Next state; a wait that reaches the timeout without ready ends in HALT
    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_q == TIMEOUT_CNT) begin
                    bus_error_d = 1'b1;
                    state_d     = ST_HALT;
                end
            end
            ST_DECODE: begin
                cls_d = dec_cls;
                case (dec_cls)
                    CL_ILL: begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                    CL_J:    state_d = ST_FETCH;
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (cls_q)
                    CL_LD, CL_ST: state_d = ST_MEM;
                    CL_BR:        state_d = ST_FETCH;
                    default:      state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    state_d = (cls_q == CL_LD) ? ST_WB : ST_FETCH;
                end else if (wait_q == TIMEOUT_CNT) begin
                    bus_error_d = 1'b1;
                    state_d     = ST_HALT;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase

        // Counter restarts on every entry into an access state
        if ((state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MEM)) begin
            wait_d = '0;
        end else if (in_access && !bus.mem_ready) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    // Datapath strobes decoded from state and class
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_op        = ALU_ADD;
        bus.pc_source     = PCSRC_ALU;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.retired       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            ST_DECODE: begin
                bus.alu_src_b = SRCB_SHIFT;
                if (dec_cls == CL_J) begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PCSRC_JUMP;
                    bus.retired   = 1'b1;
                end
            end
            ST_EXEC: begin
                bus.alu_src_a = 1'b1;
                case (cls_q)
                    CL_R: begin
                        bus.alu_src_b = SRCB_REG;
                        bus.alu_op    = ALU_FUNCT;
                    end
                    CL_IMM: begin
                        bus.alu_src_b = SRCB_SEXT;
                        bus.alu_op    = ALU_IMM;
                    end
                    CL_BR: begin
                        bus.alu_src_b     = SRCB_REG;
                        bus.alu_op        = ALU_SUB;
                        bus.pc_write_cond = 1'b1;
                        bus.pc_source     = PCSRC_ALUOUT;
                        bus.retired       = 1'b1;
                    end
                    default: begin
                        bus.alu_src_b = SRCB_SEXT;
                        bus.alu_op    = ALU_ADD;
                    end
                endcase
            end
            ST_MEM: begin
                bus.mem_req   = 1'b1;
                bus.iord      = 1'b1;
                bus.mem_read  = (cls_q == CL_LD);
                bus.mem_write = (cls_q == CL_ST);
                bus.retired   = (cls_q == CL_ST) && bus.mem_ready;
            end
            ST_WB: begin
                bus.reg_write  = 1'b1;
                bus.retired    = 1'b1;
                bus.reg_dst    = (cls_q == CL_R);
                bus.mem_to_reg = (cls_q == CL_LD);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus randomized legal
// instruction streams, checked against a cycle-timeline model of each class.
module tb_multicycle_ctrl;
  import ctrl_defs::*;

  localparam int TIMEOUT = 15;
  localparam logic [31:0] JUMP_TGT = 32'h0000_1000;
  localparam logic [31:0] BR_OFS   = 32'h0000_0040;

  typedef enum int {K_R, K_IMM, K_BR, K_J, K_LD, K_ST, K_ILL} kind_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  state_e      dbg_state;
  logic [31:0] pc;
  int          n_checks = 0;
  int          n_fail = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic kind_t kind_of(input int op);
    if (op == 0) return K_R;
    if (op == 2) return K_J;
    if (op == 1 || (op >= 4 && op <= 7)) return K_BR;
    if (op >= 8 && op <= 14) return K_IMM;
    if (op >= 32 && op <= 38) return K_LD;
    if (op >= 40 && op <= 46) return K_ST;
    return K_ILL;
  endfunction

  // cycles from first FETCH cycle to retirement with no memory waits
  function automatic int base_latency(input kind_t k);
    case (k)
      K_J:        return 2;
      K_BR:       return 3;
      K_LD:       return 5;
      K_ILL:      return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [17:0] vec(input logic req, rd, wr, io, irw, pcw, pcwc, sa,
                                      input logic [1:0] sb, ao, ps,
                                      input logic rw, rdst, m2r, ret);
    return {req, rd, wr, io, irw, pcw, pcwc, sa, sb, ao, ps, rw, rdst, m2r, ret};
  endfunction

  function automatic logic [17:0] strobes();
    return {bus.mem_req, bus.mem_read, bus.mem_write, bus.iord, bus.ir_write,
            bus.pc_write, bus.pc_write_cond, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_source, bus.reg_write, bus.reg_dst,
            bus.mem_to_reg, bus.retired};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // one cycle: inputs applied after the falling edge, outputs sampled 1ns later
  task automatic drive_cycle(input logic rdy, input logic [5:0] op, input logic z);
    @(negedge clk);
    bus.mem_ready = rdy;
    bus.opcode    = op;
    bus.zero      = z;
    #1;
  endtask

  // called 1ns after a falling edge; reset is dropped mid-cycle
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset strobes", 32'(strobes()), 32'd0);
    check("reset state", 32'(dbg_state), 32'(ST_RESET));
    check("reset flags", {30'd0, bus.illegal, bus.bus_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release state", 32'(dbg_state), 32'(ST_RESET));
  endtask

  // runs one instruction from its first FETCH cycle; fw/mw are wait cycles
  task automatic run_instr(input int op, input logic z, input int fw, input int mw);
    kind_t       k;
    logic        mem_cls, in_fetch, in_mem, rdy;
    int          total, ms, me, rcount;
    logic [31:0] pc_start, pc_exp;
    logic        req, rd, wr, io, irw, pcw, pcwc, sa, rw, rdst, m2r, ret;
    logic [1:0]  sb, ao, ps;
    k        = kind_of(op);
    mem_cls  = (k == K_LD) || (k == K_ST);
    total    = base_latency(k) + fw + (mem_cls ? mw : 0);
    ms       = fw + 3;
    me       = fw + 3 + mw;
    rcount   = 0;
    pc_start = pc;
    for (int c = 0; c < total; c++) begin
      in_fetch = (c <= fw);
      in_mem   = mem_cls && (c >= ms) && (c <= me);
      if (in_fetch)    rdy = (c == fw);
      else if (in_mem) rdy = (c == me);
      else             rdy = 1'($urandom_range(0, 1));
      drive_cycle(rdy, (c == fw + 1) ? 6'(op) : 6'($urandom_range(0, 63)), z);
      {req, rd, wr, io, irw, pcw, pcwc, sa, rw, rdst, m2r, ret} = '0;
      sb = 2'd0; ao = 2'd0; ps = 2'd0;
      if (in_fetch) begin
        req = 1'b1; rd = 1'b1; sb = 2'd1;
        irw = (c == fw); pcw = (c == fw);
      end else if (c == fw + 1) begin
        sb = 2'd3;
        if (k == K_J) begin pcw = 1'b1; ps = 2'd2; ret = 1'b1; end
      end else if (c == fw + 2) begin
        sa = 1'b1;
        case (k)
          K_R:   begin sb = 2'd0; ao = 2'd2; end
          K_IMM: begin sb = 2'd2; ao = 2'd3; end
          K_BR:  begin sb = 2'd0; ao = 2'd1; pcwc = 1'b1; ps = 2'd1; ret = 1'b1; end
          default: begin sb = 2'd2; ao = 2'd0; end
        endcase
      end else if (in_mem) begin
        req = 1'b1; io = 1'b1;
        rd  = (k == K_LD); wr = (k == K_ST);
        ret = (k == K_ST) && (c == me);
      end else begin
        rw = 1'b1; ret = 1'b1;
        rdst = (k == K_R); m2r = (k == K_LD);
      end
      check($sformatf("strobes op%0d cyc%0d", op, c), 32'(strobes()),
            32'(vec(req, rd, wr, io, irw, pcw, pcwc, sa, sb, ao, ps, rw, rdst, m2r, ret)));
      if (bus.retired) rcount++;
      // bench-side program counter driven by the strobes
      if (bus.pc_write) pc = (bus.pc_source == 2'd2) ? JUMP_TGT : pc + 32'd4;
      else if (bus.pc_write_cond && z && bus.pc_source == 2'd1) pc = pc + BR_OFS;
    end
    if (k == K_J)            pc_exp = JUMP_TGT;
    else if (k == K_BR && z) pc_exp = pc_start + 32'd4 + BR_OFS;
    else                     pc_exp = pc_start + 32'd4;
    check($sformatf("retire count op%0d", op), rcount, (k == K_ILL) ? 0 : 1);
    check($sformatf("pc op%0d", op), pc, pc_exp);
    check($sformatf("flags op%0d", op), {30'd0, bus.illegal, bus.bus_error}, 32'd0);
  endtask

  initial begin
    int op;
    bus.opcode = 6'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    pc = 32'd0;

    // reset and first instructions
    @(negedge clk);
    #1;
    apply_reset();
    run_instr(0, 1'b0, 0, 0);    // R
    run_instr(35, 1'b0, 0, 3);   // LD, three MEM waits: 8 cycles
    run_instr(4, 1'b1, 0, 0);    // BR taken
    run_instr(4, 1'b0, 0, 0);    // BR not taken
    run_instr(9, 1'b0, 1, 0);    // IMM
    run_instr(40, 1'b0, 0, 2);   // ST
    run_instr(2, 1'b0, 0, 0);    // J
    run_instr(14, 1'b0, TIMEOUT, 0);  // FETCH ready exactly at the timeout count
    run_instr(46, 1'b0, 0, TIMEOUT);  // MEM ready exactly at the timeout count

    // randomized legal instruction stream
    for (int i = 0; i < 30; i++) begin
      do op = $urandom_range(0, 63); while (kind_of(op) == K_ILL);
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // illegal opcode: HALT with flag, all strobes quiet
    run_instr(63, 1'b0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'b0);
      check($sformatf("halt strobes cyc%0d", c), 32'(strobes()), 32'd0);
      check($sformatf("illegal cyc%0d", c), {31'd0, bus.illegal}, 32'd1);
      check($sformatf("halt state cyc%0d", c), 32'(dbg_state), 32'(ST_HALT));
    end
    apply_reset();

    // FETCH never answered: bus error after TIMEOUT+1 cycles
    for (int c = 0; c <= TIMEOUT; c++) begin
      drive_cycle(1'b0, 6'($urandom_range(0, 63)), 1'b0);
      check($sformatf("fetch wait cyc%0d", c), 32'(strobes()),
            32'(vec(1, 1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0)));
      check($sformatf("no bus_error cyc%0d", c), {31'd0, bus.bus_error}, 32'd0);
    end
    drive_cycle(1'b1, 6'd0, 1'b0);
    check("bus_error set", {31'd0, bus.bus_error}, 32'd1);
    check("bus_error halt", 32'(dbg_state), 32'(ST_HALT));
    check("bus_error strobes", 32'(strobes()), 32'd0);
    apply_reset();

    // reset dropped while a store waits in MEM
    drive_cycle(1'b1, 6'd0, 1'b0);
    drive_cycle(1'b0, 6'd41, 1'b0);
    drive_cycle(1'b0, 6'd0, 1'b0);
    drive_cycle(1'b0, 6'd0, 1'b0);
    check("st mem strobes", 32'(strobes()),
          32'(vec(1, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0)));
    apply_reset();
    run_instr(0, 1'b0, 0, 0);    // restart begins at FETCH
    run_instr(33, 1'b0, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the processor datapath. Decodes the 6-bit opcode into an instruction class and steps the shared datapath through FETCH / DECODE / EXEC / MEM / WB states. Generates every per-cycle datapath strobe and waits on a ready/valid memory handshake with a timeout. Sits between the instruction register and the datapath; the single-cycle decoder is retired in this configuration.

## Interface
- `MEM_TIMEOUT`, 15 — maximum wait cycles for `mem_ready` before a bus error; legal range 1–255.
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst_n`  in  1  — reset is asynchronous and active-low.
- `opcode`  in  6  — IR[31:26]; sampled only in DECODE.
- `zero`  in  1  — ALU zero flag; sampled in EXEC of a branch.
- `mem_ready`  in  1  — memory completes the current access this cycle.
- `mem_req`  out  1  — memory access pending; held until `mem_ready`.
- `mem_read`, `mem_write`  out  1 each  — access direction; qualified by `mem_req`.
- `iord`  out  1  — memory address select: 0 = PC, 1 = ALU result.
- `ir_write`, `pc_write`, `pc_write_cond`  out  1 each  — register enables.
- `alu_src_a`  out  1  — 0 = PC, 1 = register A.
- `alu_src_b`  out  2  — 0 = B, 1 = constant 4, 2 = sign-extended immediate, 3 = shifted immediate.
- `alu_op`  out  2  — 0 = add, 1 = subtract (branch compare), 2 = funct field, 3 = immediate op.
- `pc_source`  out  2  — 0 = ALU, 1 = ALUOut (branch target), 2 = jump target.
- `reg_write`, `reg_dst`, `mem_to_reg`  out  1 each  — register-file write controls.
- `illegal`  out  1  — sticky; set on an unknown opcode.
- `bus_error`  out  1  — sticky; set on memory timeout.
- `retired`  out  1  — one-cycle pulse when an instruction completes.

## Operation
- Opcode classes:
  - 0 → R.
  - 8–14 → IMM.
  - 1, 4–7 → BR.
  - 2 → J.
  - 32–38 → LD.
  - 40–46 → ST.
  - anything else → ILL.
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, HALT.
- RESET:
  - All outputs 0.
  - Moves to FETCH on the first clock edge after `rst_n` rises.
- FETCH:
  - `mem_req=1`, `mem_read=1`, `iord=0`, `alu_src_a=0`, `alu_src_b=1`, `alu_op=0`.
  - When `mem_ready=1`: `ir_write=1`, `pc_write=1` (PC+4), go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch the class from `opcode`.
  - Compute the branch target: `alu_src_a=0`, `alu_src_b=3`, `alu_op=0`.
  - ILL → set `illegal`, go to HALT.
  - J → `pc_write=1`, `pc_source=2`, pulse `retired`, go to FETCH.
  - All other classes → EXEC.
- EXEC, per class:
  - R: `alu_src_a=1`, `alu_src_b=0`, `alu_op=2`; then WB.
  - IMM: `alu_src_a=1`, `alu_src_b=2`, `alu_op=3`; then WB.
  - LD and ST: `alu_src_a=1`, `alu_src_b=2`, `alu_op=0`; then MEM.
  - BR: `alu_src_a=1`, `alu_src_b=0`, `alu_op=1`, `pc_write_cond=1`, `pc_source=1`; PC loads the target iff `zero=1`; pulse `retired`; then FETCH.
- MEM:
  - `mem_req=1`, `iord=1`; `mem_read=1` for LD, `mem_write=1` for ST.
  - On `mem_ready`: LD → WB; ST → pulse `retired`, go to FETCH.
- WB:
  - `reg_write=1`, `retired=1`, then FETCH.
  - R: `reg_dst=1`. IMM: `reg_dst=0`. LD: `mem_to_reg=1`, `reg_dst=0`.
- Memory wait counter:
  - 8 bits; cleared on entry to FETCH or MEM; increments each cycle `mem_req=1` and `mem_ready=0`.
  - When the count reaches `MEM_TIMEOUT`, the next cycle sets `bus_error` and enters HALT.
  - `mem_ready=1` on the same cycle the count reaches `MEM_TIMEOUT` completes the access normally; no error.
- HALT:
  - All strobes 0. Remains in HALT until reset.
  - `illegal` and `bus_error` hold their values in HALT.

## Timing
- All outputs are Moore outputs: decoded from the state register plus the latched class.
- Exception: `ir_write`, `pc_write`, `retired`, and the MEM-state exits are also qualified by `mem_ready`.
- Minimum latencies with `mem_ready` tied high:
  - J: 2 cycles. BR: 3. ST: 4. R and IMM: 4. LD: 5.
- Each memory wait cycle adds exactly one cycle.
- `mem_req` never drops while an access is waiting; the address select (`iord`) is stable while `mem_req=1`.
- Reset asserted mid-access: immediate return to RESET; all outputs 0 within the same cycle (asynchronous); sticky flags cleared.
- `opcode` may change in any state other than DECODE without effect.

## Structure
- Shared package/include `ctrl_defs` holds:
  - state encodings (3 bits);
  - class encodings (3 bits);
  - `alu_op`, `alu_src_b`, and `pc_source` constants;
  - the opcode range boundaries (0, 1, 2, 4–7, 8–14, 32–38, 40–46).
- One sub-module, `opcode_class`: combinational opcode → class decoder, reused by the assembler-check bench.

## Test plan
- Reset, then R-type (opcode 0) with `mem_ready=1` → states FETCH, DECODE, EXEC, WB; `reg_write=1` and `reg_dst=1` in cycle 4; `retired` pulses once.
- LD (opcode 35) with `mem_ready` low for 3 MEM cycles → total 8 cycles; `mem_to_reg=1` in WB; `iord=1` throughout MEM.
- BR (opcode 4): `zero=1` → `pc_write_cond=1` and `pc_source=1` in EXEC; repeat with `zero=0` → the same strobes, and the bench's PC is unchanged.
- Opcode 63 → `illegal=1` one cycle after DECODE; stays in HALT with all strobes 0 for 20 cycles; `rst_n` pulse clears it.
- `mem_ready` held low in FETCH → `bus_error=1` after `MEM_TIMEOUT`+1 cycles; `mem_ready` first rising at count 15 → no error.
- `rst_n` dropped during MEM of an ST → `mem_write` and `mem_req` fall asynchronously; restart begins at FETCH.
